// File: rtl/dcache_read_ctrl_pkg.sv
// rtl/dcache_read_ctrl_pkg.sv - shared widths, state encodings and burst buffer helper
package dcache_read_ctrl_pkg;

  localparam int LINE_W       = 128;
  localparam int BURST_DW_MAX = 3;
  localparam int RESULT_W     = 64;
  localparam int BURST_W      = 32 * BURST_DW_MAX;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_COLLECT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Returns the burst buffer with one returned dword written at slot idx.
  function automatic logic [BURST_W-1:0] put_dword(input logic [BURST_W-1:0] line_buf,
                                                   input logic [1:0]         idx,
                                                   input logic [31:0]        dword);
    logic [BURST_W-1:0] r;
    r = line_buf;
    case (idx)
      2'd0:    r[31:0]  = dword;
      2'd1:    r[63:32] = dword;
      default: r[95:64] = dword;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dcache_read_align.sv
// rtl/dcache_read_align.sv - burst dword count and byte-shift amounts for one read
module dcache_read_align
  import dcache_read_ctrl_pkg::*;
(
  input  logic [3:0] addr_lo,
  input  logic [3:0] length,
  output logic [1:0] dword_len,
  output logic [6:0] line_shift,
  output logic [4:0] burst_shift
);

  logic [4:0] span;
  logic       unused_span;

  // Index of the last byte relative to the first dword; its dword number plus one is the burst size.
  assign span        = {3'b000, addr_lo[1:0]} + {1'b0, length} - 5'd1;
  assign dword_len   = span[3:2] + 2'd1;
  assign unused_span = ^{span[4], span[1:0]};

  assign line_shift  = {addr_lo, 3'b000};
  assign burst_shift = {addr_lo[1:0], 3'b000};

endmodule

// File: rtl/dcache_read_ctrl.sv
// rtl/dcache_read_ctrl.sv - data-cache read sequencer: line hit extract or 1-3 dword memory burst
module dcache_read_ctrl
  import dcache_read_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_do,
  input  logic [31:0]         req_address,
  input  logic [3:0]          req_length,
  input  logic                req_hit,
  input  logic [LINE_W-1:0]   req_line,
  output logic                req_done,
  output logic [RESULT_W-1:0] req_data,
  output logic                mem_read_do,
  output logic [29:0]         mem_read_address,
  output logic [1:0]          mem_read_dword_length,
  output logic [3:0]          mem_read_byte_length,
  input  logic                mem_read_accept,
  input  logic                mem_readdatavalid,
  input  logic [31:0]         mem_readdata
);

  logic [1:0]         state;
  logic [1:0]         addr_lo_q;
  logic [1:0]         word_cnt;
  logic [BURST_W-1:0] line_buf;
  logic [BURST_W-1:0] buf_next;

  logic [3:0] al_addr;
  logic [3:0] al_length;
  logic [1:0] al_dwl;
  logic [6:0] al_line_shift;
  logic [4:0] al_burst_shift;

  // In IDLE the aligner sees the live request; afterwards the latched request.
  assign al_addr   = (state == ST_IDLE) ? req_address[3:0] : {2'b00, addr_lo_q};
  assign al_length = (state == ST_IDLE) ? req_length       : mem_read_byte_length;

  dcache_read_align u_align (
    .addr_lo     (al_addr),
    .length      (al_length),
    .dword_len   (al_dwl),
    .line_shift  (al_line_shift),
    .burst_shift (al_burst_shift)
  );

  assign buf_next = put_dword(line_buf, word_cnt, mem_readdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= ST_IDLE;
      addr_lo_q             <= '0;
      word_cnt              <= '0;
      line_buf              <= '0;
      req_done              <= 1'b0;
      req_data              <= '0;
      mem_read_do           <= 1'b0;
      mem_read_address      <= '0;
      mem_read_dword_length <= '0;
      mem_read_byte_length  <= '0;
    end else begin
      req_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_do) begin
            addr_lo_q            <= req_address[1:0];
            mem_read_byte_length <= req_length;
            if (req_hit) begin
              req_data <= RESULT_W'(req_line >> al_line_shift);
              req_done <= 1'b1;
              state    <= ST_DONE;
            end else begin
              mem_read_do           <= 1'b1;
              mem_read_address      <= req_address[31:2];
              mem_read_dword_length <= al_dwl;
              line_buf              <= '0;
              word_cnt              <= '0;
              state                 <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (mem_read_accept) begin
            mem_read_do <= 1'b0;
            state       <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (mem_readdatavalid) begin
            line_buf <= buf_next;
            word_cnt <= word_cnt + 2'd1;
            if (word_cnt == mem_read_dword_length - 2'd1) begin
              req_data <= RESULT_W'(buf_next >> al_burst_shift);
              req_done <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
